// File: rtl/pipe_hazard_if.sv
// Hazard-controller signal bundle: decode/execute/memory hazard inputs and the
// pipeline-register enable, flush and bubble controls driven back to the core.
interface pipe_hazard_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_Rn;
    logic [4:0]       id_Rm;
    logic             id_uses_rn;
    logic             id_uses_rm;
    logic             ex_read_en;
    logic [4:0]       ex_Rd;
    logic             mem_access;
    logic             br_taken;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             back_we;
    logic [CNT_W-1:0] stall_cnt;

    // Controller side: consumes hazard info, produces pipeline controls
    modport master (
        input  id_Rn, id_Rm, id_uses_rn, id_uses_rm, ex_read_en, ex_Rd,
               mem_access, br_taken,
        output pc_we, ifid_we, ifid_flush, idex_bubble, back_we, stall_cnt
    );

    // Pipeline side: supplies hazard info, obeys the controls
    modport slave (
        output id_Rn, id_Rm, id_uses_rn, id_uses_rm, ex_read_en, ex_Rd,
               mem_access, br_taken,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, back_we, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/bubble sequencer for the five-stage pipe: load-use bubbles, taken
// branch flushes and whole-pipe freezes during multi-cycle data-memory accesses.
module pipe_hazard_ctrl #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 32
) (
    input  logic          clk,
    input  logic          reset,
    pipe_hazard_if.master hz
);
    localparam int WAIT_W    = $clog2(MEM_LAT) + 1;
    localparam bit MEM_MULTI = (MEM_LAT > 1);
    // The access cycle itself is the first freeze cycle, so MEMWAIT holds MEM_LAT-2 more.
    localparam bit GO_WAIT   = (MEM_LAT > 2);
    localparam int WAIT_LOAD = (MEM_LAT > 3) ? (MEM_LAT - 3) : 0;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_LOAD);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [WAIT_W-1:0]  wait_nxt_s;
    logic               armed_r;
    logic [CNT_W-1:0]   stall_cnt_r;

    logic lu_hazard_s;
    logic mem_start_s;
    logic pc_we_s;
    logic ifid_we_s;
    logic ifid_flush_s;
    logic idex_bubble_s;
    logic back_we_s;

    // Load-use detection; XZR never carries a real dependency
    always_comb begin
        lu_hazard_s = hz.ex_read_en && (hz.ex_Rd != 5'd31) &&
                      ((hz.id_uses_rn && (hz.id_Rn == hz.ex_Rd)) ||
                       (hz.id_uses_rm && (hz.id_Rm == hz.ex_Rd)));
        mem_start_s = MEM_MULTI && (state_r == RUN) && hz.mem_access && !armed_r;
    end

    // Next-state and pipeline control decode
    always_comb begin
        state_nxt_s   = state_r;
        wait_nxt_s    = wait_cnt_r;
        pc_we_s       = 1'b1;
        ifid_we_s     = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        back_we_s     = 1'b1;
        case (state_r)
            RUN: begin
                if (mem_start_s) begin
                    pc_we_s   = 1'b0;
                    ifid_we_s = 1'b0;
                    back_we_s = 1'b0;
                    if (GO_WAIT) begin
                        state_nxt_s = MEMWAIT;
                        wait_nxt_s  = WAIT_INIT;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else if (lu_hazard_s) begin
                    // Branch in ID is held and re-resolved next cycle
                    pc_we_s       = 1'b0;
                    ifid_we_s     = 1'b0;
                    idex_bubble_s = 1'b1;
                end else if (hz.br_taken) begin
                    ifid_flush_s = 1'b1;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MEMWAIT: begin
                pc_we_s   = 1'b0;
                ifid_we_s = 1'b0;
                back_we_s = 1'b0;
                if (wait_cnt_r == {WAIT_W{1'b0}}) begin
                    state_nxt_s = RUN;
                end else begin
                    wait_nxt_s = wait_cnt_r - WAIT_ONE;
                end
            end
            default: begin
                state_nxt_s = RUN;
                wait_nxt_s  = {WAIT_W{1'b0}};
            end
        endcase
    end

    // State, wait counter, re-entry guard and saturating stall counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= RUN;
            wait_cnt_r  <= {WAIT_W{1'b0}};
            armed_r     <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_nxt_s;
            // Guard stays up until MEM/WB advances past the serviced access
            if (mem_start_s) begin
                armed_r <= 1'b1;
            end else if (back_we_s) begin
                armed_r <= 1'b0;
            end else begin
                armed_r <= armed_r;
            end
            if (!pc_we_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign hz.pc_we       = reset ? pc_we_s       : 1'b1;
    assign hz.ifid_we     = reset ? ifid_we_s     : 1'b1;
    assign hz.ifid_flush  = reset ? ifid_flush_s  : 1'b0;
    assign hz.idex_bubble = reset ? idex_bubble_s : 1'b0;
    assign hz.back_we     = reset ? back_we_s     : 1'b1;
    assign hz.stall_cnt   = stall_cnt_r;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: three controller variants (MEM_LAT 3/3/1, CNT_W 8/4/8)
// share one stimulus stream and are compared against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [4:0] id_rn = 5'd0, id_rm = 5'd0, ex_rd = 5'd0;
    logic uses_rn = 1'b0, uses_rm = 1'b0, ex_read_en = 1'b0, mem_access = 1'b0, br_taken = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_if #(.CNT_W(8)) ifa ();
    pipe_hazard_if #(.CNT_W(4)) ifb ();
    pipe_hazard_if #(.CNT_W(8)) ifc ();

    pipe_hazard_ctrl #(.MEM_LAT(3), .CNT_W(8)) dut_a (.clk(clk), .reset(reset), .hz(ifa));
    pipe_hazard_ctrl #(.MEM_LAT(3), .CNT_W(4)) dut_b (.clk(clk), .reset(reset), .hz(ifb));
    pipe_hazard_ctrl #(.MEM_LAT(1), .CNT_W(8)) dut_c (.clk(clk), .reset(reset), .hz(ifc));

    assign ifa.id_Rn = id_rn;  assign ifb.id_Rn = id_rn;  assign ifc.id_Rn = id_rn;
    assign ifa.id_Rm = id_rm;  assign ifb.id_Rm = id_rm;  assign ifc.id_Rm = id_rm;
    assign ifa.ex_Rd = ex_rd;  assign ifb.ex_Rd = ex_rd;  assign ifc.ex_Rd = ex_rd;
    assign ifa.id_uses_rn = uses_rn;  assign ifb.id_uses_rn = uses_rn;  assign ifc.id_uses_rn = uses_rn;
    assign ifa.id_uses_rm = uses_rm;  assign ifb.id_uses_rm = uses_rm;  assign ifc.id_uses_rm = uses_rm;
    assign ifa.ex_read_en = ex_read_en;  assign ifb.ex_read_en = ex_read_en;  assign ifc.ex_read_en = ex_read_en;
    assign ifa.mem_access = mem_access;  assign ifb.mem_access = mem_access;  assign ifc.mem_access = mem_access;
    assign ifa.br_taken = br_taken;  assign ifb.br_taken = br_taken;  assign ifc.br_taken = br_taken;

    // Observed controls packed as {pc_we, ifid_we, ifid_flush, idex_bubble, back_we}
    logic [4:0]  obs [3];
    logic [31:0] cnt_obs [3];
    always_comb begin
        obs[0] = {ifa.pc_we, ifa.ifid_we, ifa.ifid_flush, ifa.idex_bubble, ifa.back_we};
        obs[1] = {ifb.pc_we, ifb.ifid_we, ifb.ifid_flush, ifb.idex_bubble, ifb.back_we};
        obs[2] = {ifc.pc_we, ifc.ifid_we, ifc.ifid_flush, ifc.idex_bubble, ifc.back_we};
        cnt_obs[0] = 32'(ifa.stall_cnt);
        cnt_obs[1] = 32'(ifb.stall_cnt);
        cnt_obs[2] = 32'(ifc.stall_cnt);
    end

    // Reference model: remaining frozen cycles, serviced-access guard, stall count
    int lat  [3] = '{3, 3, 1};
    int maxc [3] = '{255, 15, 255};
    int fl   [3] = '{0, 0, 0};
    bit blk  [3] = '{1'b0, 1'b0, 1'b0};
    int cnt  [3] = '{0, 0, 0};

    localparam logic [4:0] O_RUN    = 5'b11001;
    localparam logic [4:0] O_BUBBLE = 5'b00011;
    localparam logic [4:0] O_FLUSH  = 5'b11101;
    localparam logic [4:0] O_FREEZE = 5'b00000;

    function automatic bit hazard();
        return ex_read_en && (ex_rd != 5'd31) &&
               ((uses_rn && id_rn == ex_rd) || (uses_rm && id_rm == ex_rd));
    endfunction

    function automatic bit starts_access(int k);
        return reset && fl[k] == 0 && mem_access && lat[k] > 1 && !blk[k];
    endfunction

    function automatic logic [4:0] exp_out(int k);
        if (!reset) return O_RUN;
        if (fl[k] > 0 || starts_access(k)) return O_FREEZE;
        if (hazard()) return O_BUBBLE;
        if (br_taken) return O_FLUSH;
        return O_RUN;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            fl[k] = 0; blk[k] = 1'b0; cnt[k] = 0;
        end
    endtask

    // One clock edge for DUTs and model; returns #1 after the edge
    task automatic advance();
        logic [4:0] e [3];
        bit st [3];
        for (int k = 0; k < 3; k++) begin
            e[k] = exp_out(k);
            st[k] = starts_access(k);
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                fl[k] = 0; blk[k] = 1'b0; cnt[k] = 0;
            end else begin
                if (fl[k] > 0) fl[k]--;
                else if (st[k]) begin fl[k] = lat[k] - 2; blk[k] = 1'b1; end
                if (e[k][0]) blk[k] = 1'b0;
                if (!e[k][4] && cnt[k] < maxc[k]) cnt[k]++;
            end
        end
        #1;
    endtask

    task automatic clean_inputs();
        id_rn = 5'd0; id_rm = 5'd0; ex_rd = 5'd0; uses_rn = 1'b0; uses_rm = 1'b0;
        ex_read_en = 1'b0; mem_access = 1'b0; br_taken = 1'b0;
    endtask

    task automatic test_reset();
        clean_inputs();
        ex_read_en = 1'b1; ex_rd = 5'd4; id_rn = 5'd4; uses_rn = 1'b1; br_taken = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== O_RUN) begin
                    errors++; $display("FAIL reset_outs dut%0d got %b expected %b", k, obs[k], O_RUN);
                end
                checks++;
                if (cnt_obs[k] !== 32'd0) begin
                    errors++; $display("FAIL reset_cnt dut%0d got %0d expected 0", k, cnt_obs[k]);
                end
            end
            if (c == 0) advance();
        end
        reset = 1'b1;
        clean_inputs();
        advance();
    endtask

    task automatic test_load_use();
        for (int c = 0; c < 4; c++) begin
            clean_inputs();
            ex_read_en = (c % 2 == 0); ex_rd = 5'd3;
            if (c < 2) begin id_rn = 5'd3; uses_rn = 1'b1; end
            else begin id_rm = 5'd3; uses_rm = 1'b1; id_rn = 5'd3; end
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== ((c % 2 == 0) ? O_BUBBLE : O_RUN)) begin
                    errors++; $display("FAIL load_use c%0d dut%0d got %b expected %b",
                                       c, k, obs[k], (c % 2 == 0) ? O_BUBBLE : O_RUN);
                end
                checks++;
                if (cnt_obs[k] !== 32'((c + 1) / 2)) begin
                    errors++; $display("FAIL load_use_cnt c%0d dut%0d got %0d expected %0d",
                                       c, k, cnt_obs[k], (c + 1) / 2);
                end
            end
            advance();
        end
        // uses flag low: matching register number must not stall
        clean_inputs();
        ex_read_en = 1'b1; ex_rd = 5'd9; id_rn = 5'd9; id_rm = 5'd9;
        @(negedge clk);
        checks++;
        if (obs[0] !== O_RUN) begin
            errors++; $display("FAIL no_use_flag got %b expected %b", obs[0], O_RUN);
        end
        advance();
    endtask

    task automatic test_xzr();
        clean_inputs();
        ex_read_en = 1'b1; ex_rd = 5'd31; id_rn = 5'd31; id_rm = 5'd31; uses_rn = 1'b1; uses_rm = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== O_RUN) begin
                errors++; $display("FAIL xzr dut%0d got %b expected %b", k, obs[k], O_RUN);
            end
        end
        advance();
    endtask

    task automatic test_memwait();
        int base;
        logic [4:0] want_a [4] = '{O_FREEZE, O_FREEZE, O_RUN, O_RUN};
        base = cnt[0];
        for (int c = 0; c < 4; c++) begin
            clean_inputs();
            mem_access = (c < 3);
            br_taken   = (c == 1);
            @(negedge clk);
            checks++;
            if (obs[0] !== want_a[c]) begin
                errors++; $display("FAIL memwait c%0d dut0 got %b expected %b", c, obs[0], want_a[c]);
            end
            checks++;
            if (obs[2] !== ((c == 1) ? O_FLUSH : O_RUN)) begin
                errors++; $display("FAIL memwait_lat1 c%0d got %b expected %b",
                                   c, obs[2], (c == 1) ? O_FLUSH : O_RUN);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_out(k) || cnt_obs[k] !== 32'(cnt[k])) begin
                    errors++; $display("FAIL memwait_model c%0d dut%0d got %b/%0d expected %b/%0d",
                                       c, k, obs[k], cnt_obs[k], exp_out(k), cnt[k]);
                end
            end
            advance();
        end
        checks++;
        if (cnt_obs[0] !== 32'(base + 2)) begin
            errors++; $display("FAIL memwait_cnt got %0d expected %0d", cnt_obs[0], base + 2);
        end
    endtask

    task automatic test_branch_hazard();
        for (int c = 0; c < 2; c++) begin
            clean_inputs();
            br_taken = 1'b1;
            if (c == 0) begin ex_read_en = 1'b1; ex_rd = 5'd7; id_rm = 5'd7; uses_rm = 1'b1; end
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== ((c == 0) ? O_BUBBLE : O_FLUSH)) begin
                    errors++; $display("FAIL branch_hazard c%0d dut%0d got %b expected %b",
                                       c, k, obs[k], (c == 0) ? O_BUBBLE : O_FLUSH);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_memwait();
        clean_inputs();
        mem_access = 1'b1;
        advance();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== O_RUN || cnt_obs[k] !== 32'd0) begin
                errors++; $display("FAIL reset_midwait dut%0d got %b/%0d expected %b/0",
                                   k, obs[k], cnt_obs[k], O_RUN);
            end
        end
        advance();
        @(negedge clk);
        reset = 1'b1;
        mem_access = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== O_RUN || cnt_obs[k] !== 32'd0) begin
                errors++; $display("FAIL after_reset dut%0d got %b/%0d expected %b/0",
                                   k, obs[k], cnt_obs[k], O_RUN);
            end
        end
        advance();
    endtask

    task automatic test_saturation();
        clean_inputs();
        ex_read_en = 1'b1; ex_rd = 5'd12; id_rn = 5'd12; uses_rn = 1'b1;
        for (int c = 0; c < 17; c++) advance();
        clean_inputs();
        @(negedge clk);
        checks++;
        if (cnt_obs[1] !== 32'd15) begin
            errors++; $display("FAIL saturate_b got %0d expected 15", cnt_obs[1]);
        end
        checks++;
        if (cnt_obs[0] !== 32'd17) begin
            errors++; $display("FAIL count_a got %0d expected 17", cnt_obs[0]);
        end
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [4:0] pick [4] = '{5'd1, 5'd2, 5'd3, 5'd31};
            id_rn = pick[$urandom_range(0, 3)];
            id_rm = pick[$urandom_range(0, 3)];
            ex_rd = pick[$urandom_range(0, 3)];
            uses_rn = 1'($urandom_range(0, 1));
            uses_rm = 1'($urandom_range(0, 1));
            ex_read_en = 1'($urandom_range(0, 1));
            mem_access = ($urandom_range(0, 5) == 0);
            br_taken = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 79) != 0);
            if (!reset) model_reset();
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_out(k)) begin
                    errors++; $display("FAIL random c%0d dut%0d outs got %b expected %b",
                                       c, k, obs[k], exp_out(k));
                end
                checks++;
                if (cnt_obs[k] !== 32'(cnt[k])) begin
                    errors++; $display("FAIL random c%0d dut%0d cnt got %0d expected %0d",
                                       c, k, cnt_obs[k], cnt[k]);
                end
            end
            advance();
        end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_xzr();
        test_memwait();
        test_branch_hazard();
        test_reset_memwait();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
